score_entry: RTL and testbench

Decimal keypad-to-binary score entry, the inverse of the score display path. The user keys in up to three decimal digits, which are echoed as BCD for the seven-seg drivers. On ENTER, the block converts the digits to an 8-bit binary SCORE with a sequential multiply-by-10-and-add loop, range-checks the result and commits it with a one-cycle valid pulse. It sits between the debounced key/switch front end and the game logic that consumes SCORE.

---
 rtl/score_entry_if.sv | 30 +++
 rtl/score_entry.sv | 179 +++++++++++++++++
 tb/tb_score_entry.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_entry_if.sv
// Keypad score-entry bus: keyed digits and strobes in, committed score,
// status flags and the BCD echo of the entry out.
interface score_entry_if;
  logic [3:0] digit;
  logic       digit_valid;
  logic       enter;
  logic       clear;
  logic [7:0] score;
  logic       score_valid;
  logic       error;
  logic       busy;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [1:0] digit_count;

  // Driver side: key/switch front end plus the score consumer.
  modport master (
    output digit, digit_valid, enter, clear,
    input  score, score_valid, error, busy,
    input  bcd_hundreds, bcd_tens, bcd_ones, digit_count
  );

  // Converter side.
  modport slave (
    input  digit, digit_valid, enter, clear,
    output score, score_valid, error, busy,
    output bcd_hundreds, bcd_tens, bcd_ones, digit_count
  );
endinterface

// File: rtl/score_entry.sv
// Decimal keypad to binary score entry. Up to three BCD digits are shifted
// in from the right and echoed for the display. ENTER latches them and runs
// three multiply-by-ten-and-add steps, then a commit cycle range-checks the
// result against MAX_VALUE and either publishes it or flags an error.
module score_entry #(
  parameter int unsigned MAX_VALUE = 255
) (
  input  logic         clk,
  input  logic         rst,
  score_entry_if.slave bus
);

  localparam logic [9:0] MAX_ACC = 10'(MAX_VALUE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CONV0   = 3'd2,
    CONV1   = 3'd3,
    CONV2   = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t     state_r;
  logic [3:0] hundreds_r;
  logic [3:0] tens_r;
  logic [3:0] ones_r;
  logic [1:0] count_r;
  logic [3:0] lat_hundreds_r;
  logic [3:0] lat_tens_r;
  logic [3:0] lat_ones_r;
  logic [9:0] acc_r;
  logic [7:0] score_r;
  logic       score_valid_r;
  logic       error_r;
  logic       busy_r;
  logic       digit_ok_s;

  // acc*10 + d built from two shifts and adds; acc entering a step is at
  // most 99, so the 10-bit result cannot overflow.
  function automatic logic [9:0] mul10_add(input logic [9:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {6'd0, d};
  endfunction

  // A keyed value is a usable decimal digit only in 0..9.
  function automatic logic is_decimal(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Digit acceptance needs a legal value and a free slot.
  always_comb begin
    digit_ok_s = 1'b0;
    if (is_decimal(bus.digit) && (count_r != 2'd3)) begin
      digit_ok_s = 1'b1;
    end else begin
      digit_ok_s = 1'b0;
    end
  end

  // Entry/conversion FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      hundreds_r     <= 4'd0;
      tens_r         <= 4'd0;
      ones_r         <= 4'd0;
      count_r        <= 2'd0;
      lat_hundreds_r <= 4'd0;
      lat_tens_r     <= 4'd0;
      lat_ones_r     <= 4'd0;
      acc_r          <= 10'd0;
      score_r        <= 8'd0;
      score_valid_r  <= 1'b0;
      error_r        <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      score_valid_r <= 1'b0;
      case (state_r)
        IDLE, COLLECT: begin
          if (bus.clear) begin
            hundreds_r <= 4'd0;
            tens_r     <= 4'd0;
            ones_r     <= 4'd0;
            count_r    <= 2'd0;
            error_r    <= 1'b0;
            state_r    <= IDLE;
          end else if (bus.enter) begin
            if (count_r == 2'd0) begin
              error_r <= 1'b1;
              state_r <= IDLE;
            end else begin
              lat_hundreds_r <= hundreds_r;
              lat_tens_r     <= tens_r;
              lat_ones_r     <= ones_r;
              acc_r          <= 10'd0;
              busy_r         <= 1'b1;
              state_r        <= CONV0;
            end
          end else if (bus.digit_valid) begin
            if (digit_ok_s) begin
              hundreds_r <= tens_r;
              tens_r     <= ones_r;
              ones_r     <= bus.digit;
              count_r    <= count_r + 2'd1;
              error_r    <= 1'b0;
              state_r    <= COLLECT;
            end else begin
              error_r <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end

        CONV0, CONV1, CONV2, COMMIT: begin
          if (bus.clear) begin
            // Abort: drop the entry, never commit.
            hundreds_r <= 4'd0;
            tens_r     <= 4'd0;
            ones_r     <= 4'd0;
            count_r    <= 2'd0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            case (state_r)
              CONV0: begin
                acc_r   <= {6'd0, lat_hundreds_r};
                state_r <= CONV1;
              end
              CONV1: begin
                acc_r   <= mul10_add(acc_r, lat_tens_r);
                state_r <= CONV2;
              end
              CONV2: begin
                acc_r   <= mul10_add(acc_r, lat_ones_r);
                state_r <= COMMIT;
              end
              COMMIT: begin
                if (acc_r <= MAX_ACC) begin
                  score_r       <= acc_r[7:0];
                  score_valid_r <= 1'b1;
                  error_r       <= 1'b0;
                end else begin
                  error_r <= 1'b1;
                end
                hundreds_r <= 4'd0;
                tens_r     <= 4'd0;
                ones_r     <= 4'd0;
                count_r    <= 2'd0;
                busy_r     <= 1'b0;
                state_r    <= IDLE;
              end
              default: begin
                busy_r  <= 1'b0;
                state_r <= IDLE;
              end
            endcase
          end
        end

        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.score        = score_r;
  assign bus.score_valid  = score_valid_r;
  assign bus.error        = error_r;
  assign bus.busy         = busy_r;
  assign bus.bcd_hundreds = hundreds_r;
  assign bus.bcd_tens     = tens_r;
  assign bus.bcd_ones     = ones_r;
  assign bus.digit_count  = count_r;

endmodule

// File: tb/tb_score_entry.sv
// Directed bench for score_entry: a default build (MAX_VALUE=255) and a
// MAX_VALUE=100 build share one stimulus stream; expected values are
// hand-computed constants.
module tb_score_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dg  = 4'd0;
  logic       dv  = 1'b0;
  logic       en  = 1'b0;
  logic       cl  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  score_entry_if if_a ();
  score_entry_if if_b ();

  assign if_a.digit       = dg;
  assign if_a.digit_valid = dv;
  assign if_a.enter       = en;
  assign if_a.clear       = cl;
  assign if_b.digit       = dg;
  assign if_b.digit_valid = dv;
  assign if_b.enter       = en;
  assign if_b.clear       = cl;

  score_entry #(.MAX_VALUE(255)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  score_entry #(.MAX_VALUE(100)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    dg = d;
    dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic chk_entry(input string tag, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o, input logic [1:0] c);
    chk({tag, ".hundreds"}, {6'd0, if_a.bcd_hundreds}, {6'd0, h});
    chk({tag, ".tens"},     {6'd0, if_a.bcd_tens},     {6'd0, t});
    chk({tag, ".ones"},     {6'd0, if_a.bcd_ones},     {6'd0, o});
    chk({tag, ".count"},    {8'd0, if_a.digit_count},  {8'd0, c});
  endtask

  // Pulses ENTER, checks BUSY across edges k..k+3, returns just after k+4.
  task automatic enter_and_wait(input string tag);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk({tag, ".busy_k"}, {9'd0, if_a.busy}, 10'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, ".busy_mid"}, {9'd0, if_a.busy}, 10'd1);
      chk({tag, ".sv_mid"}, {9'd0, if_a.score_valid}, 10'd0);
    end
    tick();
    chk({tag, ".busy_done"}, {9'd0, if_a.busy}, 10'd0);
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst.score", {2'd0, if_a.score}, 10'd0);
    chk("rst.sv", {9'd0, if_a.score_valid}, 10'd0);
    chk("rst.error", {9'd0, if_a.error}, 10'd0);
    chk("rst.busy", {9'd0, if_a.busy}, 10'd0);
    chk_entry("rst", 4'd0, 4'd0, 4'd0, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1,2,7 -> 127
    key(4'd1);
    chk_entry("k1", 4'd0, 4'd0, 4'd1, 2'd1);
    key(4'd2);
    key(4'd7);
    chk_entry("k127", 4'd1, 4'd2, 4'd7, 2'd3);
    enter_and_wait("e127");
    chk("e127.score", {2'd0, if_a.score}, 10'd127);
    chk("e127.sv", {9'd0, if_a.score_valid}, 10'd1);
    chk("e127.error", {9'd0, if_a.error}, 10'd0);
    chk_entry("e127.post", 4'd0, 4'd0, 4'd0, 2'd0);
    tick();
    chk("e127.sv_drop", {9'd0, if_a.score_valid}, 10'd0);
    chk("e127.hold", {2'd0, if_a.score}, 10'd127);

    // 2,5,6 -> out of range
    key(4'd2);
    key(4'd5);
    key(4'd6);
    enter_and_wait("e256");
    chk("e256.sv", {9'd0, if_a.score_valid}, 10'd0);
    chk("e256.score", {2'd0, if_a.score}, 10'd127);
    chk("e256.error", {9'd0, if_a.error}, 10'd1);
    chk_entry("e256.post", 4'd0, 4'd0, 4'd0, 2'd0);
    key(4'd9);
    chk("k9.error", {9'd0, if_a.error}, 10'd0);
    chk_entry("k9", 4'd0, 4'd0, 4'd9, 2'd1);
    cl = 1'b1;
    tick();
    cl = 1'b0;
    chk_entry("clr", 4'd0, 4'd0, 4'd0, 2'd0);

    // 4,2,1,8 (overflow), then illegal 0xC
    key(4'd4);
    key(4'd2);
    key(4'd1);
    key(4'd8);
    chk("k4th.error", {9'd0, if_a.error}, 10'd1);
    chk_entry("k4th", 4'd4, 4'd2, 4'd1, 2'd3);
    key(4'hC);
    chk("kC.error", {9'd0, if_a.error}, 10'd1);
    chk_entry("kC", 4'd4, 4'd2, 4'd1, 2'd3);
    enter_and_wait("e421");
    chk("e421.sv", {9'd0, if_a.score_valid}, 10'd0);
    chk("e421.error", {9'd0, if_a.error}, 10'd1);
    chk("e421.score", {2'd0, if_a.score}, 10'd127);

    // Illegal digit alone in IDLE sets ERROR, leaves entry empty
    cl = 1'b1;
    tick();
    cl = 1'b0;
    key(4'hA);
    chk("kA.error", {9'd0, if_a.error}, 10'd1);
    chk_entry("kA", 4'd0, 4'd0, 4'd0, 2'd0);

    // Single 0 -> SCORE 0
    key(4'd0);
    chk("k0.error", {9'd0, if_a.error}, 10'd0);
    chk_entry("k0", 4'd0, 4'd0, 4'd0, 2'd1);
    enter_and_wait("e0");
    chk("e0.score", {2'd0, if_a.score}, 10'd0);
    chk("e0.sv", {9'd0, if_a.score_valid}, 10'd1);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("eempty.error", {9'd0, if_a.error}, 10'd1);
    chk("eempty.busy", {9'd0, if_a.busy}, 10'd0);

    // 9,9, ENTER, CLEAR one cycle later -> abort
    key(4'd9);
    key(4'd9);
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("abort.busy_k", {9'd0, if_a.busy}, 10'd1);
    cl = 1'b1;
    tick();
    cl = 1'b0;
    chk("abort.busy", {9'd0, if_a.busy}, 10'd0);
    chk("abort.error", {9'd0, if_a.error}, 10'd0);
    chk_entry("abort", 4'd0, 4'd0, 4'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort.sv", {9'd0, if_a.score_valid}, 10'd0);
    end
    chk("abort.score", {2'd0, if_a.score}, 10'd0);

    // ENTER + DIGIT_VALID together with empty entry
    en = 1'b1;
    dv = 1'b1;
    dg = 4'd3;
    tick();
    en = 1'b0;
    dv = 1'b0;
    chk("entdig.error", {9'd0, if_a.error}, 10'd1);
    chk("entdig.busy", {9'd0, if_a.busy}, 10'd0);
    chk_entry("entdig", 4'd0, 4'd0, 4'd0, 2'd0);

    // Commit 42, then async reset mid-CONV1
    key(4'd4);
    key(4'd2);
    enter_and_wait("e42");
    chk("e42.score", {2'd0, if_a.score}, 10'd42);
    chk("e42.b_score", {2'd0, if_b.score}, 10'd42);
    key(4'd5);
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.score", {2'd0, if_a.score}, 10'd0);
    chk("arst.busy", {9'd0, if_a.busy}, 10'd0);
    chk("arst.b_score", {2'd0, if_b.score}, 10'd0);
    chk_entry("arst", 4'd0, 4'd0, 4'd0, 2'd0);
    tick();
    rst = 1'b0;
    tick();

    // 100 then 101 against both builds
    key(4'd1);
    key(4'd0);
    key(4'd0);
    enter_and_wait("e100");
    chk("e100.a_score", {2'd0, if_a.score}, 10'd100);
    chk("e100.b_score", {2'd0, if_b.score}, 10'd100);
    chk("e100.b_sv", {9'd0, if_b.score_valid}, 10'd1);
    chk("e100.b_error", {9'd0, if_b.error}, 10'd0);
    key(4'd1);
    key(4'd0);
    key(4'd1);
    enter_and_wait("e101");
    chk("e101.a_score", {2'd0, if_a.score}, 10'd101);
    chk("e101.a_sv", {9'd0, if_a.score_valid}, 10'd1);
    chk("e101.b_score", {2'd0, if_b.score}, 10'd100);
    chk("e101.b_sv", {9'd0, if_b.score_valid}, 10'd0);
    chk("e101.b_error", {9'd0, if_b.error}, 10'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
